// File: rtl/cpu_image_loader.sv
// Boot-image loader: accepts a header+payload word stream, writes instruction and data
// memory, zero-fills the unused tails, clears the register file, then releases the CPU.
module cpu_image_loader #(
   parameter int IMEM_DEPTH = 256,
   parameter int DMEM_DEPTH = 32,
   parameter int RF_DEPTH   = 32
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        load_valid_i,
   output logic        load_ready_o,
   input  logic [31:0] load_data_i,
   input  logic        load_last_i,
   output logic        imem_we_o,
   output logic [7:0]  imem_addr_o,
   output logic [31:0] imem_data_o,
   output logic        dmem_we_o,
   output logic [4:0]  dmem_addr_o,
   output logic [31:0] dmem_data_o,
   output logic        rf_we_o,
   output logic [4:0]  rf_addr_o,
   output logic [31:0] rf_data_o,
   output logic        cpu_rst_o,
   output logic        start_o,
   output logic        done_o,
   output logic        err_o
);

   typedef enum logic [3:0] {
      HDR_I, HDR_D, LOAD_I, LOAD_D, FILL_I, FILL_D, CLR_RF, RUN, ERR
   } state_t;

   localparam logic [31:0] IMEM_LIM  = 32'(IMEM_DEPTH);
   localparam logic [31:0] DMEM_LIM  = 32'(DMEM_DEPTH);
   localparam logic [8:0]  IMEM_FULL = 9'(IMEM_DEPTH);
   localparam logic [8:0]  IMEM_LAST = 9'(IMEM_DEPTH - 1);
   localparam logic [5:0]  DMEM_FULL = 6'(DMEM_DEPTH);
   localparam logic [5:0]  DMEM_LAST = 6'(DMEM_DEPTH - 1);
   localparam logic [4:0]  RF_LAST   = 5'(RF_DEPTH - 1);

   state_t     state;
   logic [8:0] icnt, n_q;
   logic [5:0] dcnt, m_q;
   logic [4:0] rcnt;
   logic       xfer, last_i_exp, last_d_exp;
   state_t     after_data;

   // Gated with reset so ready is low while reset is held yet high on the first free cycle.
   assign load_ready_o = rst_i && (state inside {HDR_I, HDR_D, LOAD_I, LOAD_D});
   assign xfer         = load_valid_i && load_ready_o;
   assign rf_data_o    = '0;

   always_comb begin
      last_i_exp = ((icnt + 9'd1) == n_q) && (m_q == '0);
      last_d_exp = ((dcnt + 6'd1) == m_q);
      if (n_q != IMEM_FULL)
         after_data = FILL_I;
      else if (m_q != DMEM_FULL)
         after_data = FILL_D;
      else
         after_data = CLR_RF;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state       <= HDR_I;
         icnt        <= '0;
         n_q         <= '0;
         dcnt        <= '0;
         m_q         <= '0;
         rcnt        <= '0;
         imem_we_o   <= 1'b0;
         imem_addr_o <= '0;
         imem_data_o <= '0;
         dmem_we_o   <= 1'b0;
         dmem_addr_o <= '0;
         dmem_data_o <= '0;
         rf_we_o     <= 1'b0;
         rf_addr_o   <= '0;
         cpu_rst_o   <= 1'b1;
         start_o     <= 1'b0;
         done_o      <= 1'b0;
         err_o       <= 1'b0;
      end else begin
         imem_we_o <= 1'b0;
         dmem_we_o <= 1'b0;
         rf_we_o   <= 1'b0;
         unique case (state)
            HDR_I: if (xfer) begin
               if (load_last_i || load_data_i == '0 || load_data_i > IMEM_LIM) begin
                  state <= ERR;
                  err_o <= 1'b1;
               end else begin
                  n_q   <= load_data_i[8:0];
                  state <= HDR_D;
               end
            end
            HDR_D: if (xfer) begin
               if (load_last_i || load_data_i > DMEM_LIM) begin
                  state <= ERR;
                  err_o <= 1'b1;
               end else begin
                  m_q   <= load_data_i[5:0];
                  state <= LOAD_I;
               end
            end
            LOAD_I: if (xfer) begin
               if (load_last_i != last_i_exp) begin
                  state <= ERR;
                  err_o <= 1'b1;
               end else begin
                  imem_we_o   <= 1'b1;
                  imem_addr_o <= icnt[7:0];
                  imem_data_o <= load_data_i;
                  icnt        <= icnt + 9'd1;
                  if ((icnt + 9'd1) == n_q)
                     state <= (m_q != '0) ? LOAD_D : after_data;
               end
            end
            LOAD_D: if (xfer) begin
               if (load_last_i != last_d_exp) begin
                  state <= ERR;
                  err_o <= 1'b1;
               end else begin
                  dmem_we_o   <= 1'b1;
                  dmem_addr_o <= dcnt[4:0];
                  dmem_data_o <= load_data_i;
                  dcnt        <= dcnt + 6'd1;
                  if ((dcnt + 6'd1) == m_q)
                     state <= after_data;
               end
            end
            FILL_I: begin
               imem_we_o   <= 1'b1;
               imem_addr_o <= icnt[7:0];
               imem_data_o <= '0;
               icnt        <= icnt + 9'd1;
               if (icnt == IMEM_LAST)
                  state <= (m_q != DMEM_FULL) ? FILL_D : CLR_RF;
            end
            FILL_D: begin
               dmem_we_o   <= 1'b1;
               dmem_addr_o <= dcnt[4:0];
               dmem_data_o <= '0;
               dcnt        <= dcnt + 6'd1;
               if (dcnt == DMEM_LAST)
                  state <= CLR_RF;
            end
            CLR_RF: begin
               rf_we_o   <= 1'b1;
               rf_addr_o <= rcnt;
               rcnt      <= rcnt + 5'd1;
               if (rcnt == RF_LAST)
                  state <= RUN;
            end
            // Release lands one cycle after the final register-clear strobe.
            RUN: begin
               cpu_rst_o <= 1'b0;
               start_o   <= 1'b1;
               done_o    <= 1'b1;
            end
            ERR: begin
               err_o     <= 1'b1;
               cpu_rst_o <= 1'b1;
               start_o   <= 1'b0;
            end
            default: begin
               state <= ERR;
               err_o <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_image_loader.sv
// Randomised image-loading bench: a list-level model of the expected write sequence,
// error position and release timing is compared against strobes captured from the loader.
module tb_cpu_image_loader;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        load_valid_i;
   logic        load_ready_o;
   logic [31:0] load_data_i;
   logic        load_last_i;
   logic        imem_we_o;
   logic [7:0]  imem_addr_o;
   logic [31:0] imem_data_o;
   logic        dmem_we_o;
   logic [4:0]  dmem_addr_o;
   logic [31:0] dmem_data_o;
   logic        rf_we_o;
   logic [4:0]  rf_addr_o;
   logic [31:0] rf_data_o;
   logic        cpu_rst_o, start_o, done_o, err_o;

   cpu_image_loader #(.IMEM_DEPTH(256), .DMEM_DEPTH(32), .RF_DEPTH(32)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .load_valid_i(load_valid_i), .load_ready_o(load_ready_o),
      .load_data_i(load_data_i), .load_last_i(load_last_i),
      .imem_we_o(imem_we_o), .imem_addr_o(imem_addr_o), .imem_data_o(imem_data_o),
      .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o), .dmem_data_o(dmem_data_o),
      .rf_we_o(rf_we_o), .rf_addr_o(rf_addr_o), .rf_data_o(rf_data_o),
      .cpu_rst_o(cpu_rst_o), .start_o(start_o), .done_o(done_o), .err_o(err_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      int          kind;   // 0 imem, 1 dmem, 2 rf
      int          addr;
      logic [31:0] data;
      int          cyc;
   } evt_t;

   evt_t        got[$];
   evt_t        expq[$];
   int          xfer_q[$];
   logic [31:0] img[$];
   int          cyc = 0;
   int          multi = 0;
   int          start_cyc = -1;
   int          err_cyc = -1;
   int          npass = 0;
   int          nchk = 0;
   string       tname = "init";

   function automatic evt_t mk(input int kind, input int addr, input logic [31:0] data, input int c);
      evt_t e;
      e.kind = kind; e.addr = addr; e.data = data; e.cyc = c;
      return e;
   endfunction

   // A transfer is logged with the current cycle; its strobe is expected one negedge later.
   always @(posedge clk_i)
      if (rst_i && load_valid_i && load_ready_o) xfer_q.push_back(cyc);

   always @(negedge clk_i) begin
      cyc = cyc + 1;
      if (int'(imem_we_o) + int'(dmem_we_o) + int'(rf_we_o) > 1) multi = multi + 1;
      if (imem_we_o) got.push_back(mk(0, int'(imem_addr_o), imem_data_o, cyc));
      if (dmem_we_o) got.push_back(mk(1, int'(dmem_addr_o), dmem_data_o, cyc));
      if (rf_we_o)   got.push_back(mk(2, int'(rf_addr_o), rf_data_o, cyc));
      if (start_o && start_cyc < 0) start_cyc = cyc;
      if (err_o && err_cyc < 0) err_cyc = cyc;
   end

   task automatic check(input string tag, input int obs, input int expv);
      nchk = nchk + 1;
      assert (obs === expv) npass = npass + 1;
      else $error("FAIL %s.%s observed=%0d expected=%0d", tname, tag, obs, expv);
   endtask

   task automatic clear_mon();
      got.delete();
      xfer_q.delete();
      multi = 0;
      start_cyc = -1;
      err_cyc = -1;
   endtask

   task automatic do_reset();
      @(negedge clk_i); #2;
      rst_i = 1'b0;
      load_valid_i = 1'b0;
      load_last_i = 1'b0;
      repeat (2) @(negedge clk_i);
      check("rst_strobes", int'({imem_we_o, dmem_we_o, rf_we_o}), 0);
      check("rst_ready", int'(load_ready_o), 0);
      check("rst_cpu_rst", int'(cpu_rst_o), 1);
      check("rst_flags", int'({start_o, done_o, err_o}), 0);
      check("rst_addrs", int'(imem_addr_o) + int'(dmem_addr_o) + int'(rf_addr_o), 0);
      check("rst_data", int'((imem_data_o | dmem_data_o | rf_data_o) != 0), 0);
      #2;
      clear_mon();
      rst_i = 1'b1;
      @(negedge clk_i);
      check("ready_after_release", int'(load_ready_o), 1);
      #2;
   endtask

   task automatic build_img(input int n, input int m);
      int nw;
      img.delete();
      img.push_back(32'(n));
      img.push_back(32'(m));
      nw = (n > 300 ? 300 : n) + (m > 40 ? 40 : m);
      for (int i = 0; i < nw; i++) img.push_back($urandom);
   endtask

   task automatic send(input logic [31:0] w, input logic l, input int gap, output bit ok);
      int t = 0;
      int g = (gap == 2) ? int'($urandom_range(0, 2)) : gap;
      for (int i = 0; i < g; i++) begin @(negedge clk_i); #2; end
      load_valid_i = 1'b1;
      load_data_i  = w;
      load_last_i  = l;
      while (!load_ready_o && t < 100) begin @(negedge clk_i); #2; t++; end
      ok = load_ready_o;
      @(negedge clk_i); #2;
      load_valid_i = 1'b0;
      load_last_i  = 1'b0;
   endtask

   task automatic run_image(input int early_last, input bit drop_last, input int gap, input bit verify);
      int n = int'(img[0]);
      int m = int'(img[1]);
      int total = img.size();
      bit lasts[$];
      int e = -1;
      int last_send, nload, bad, tbad, gaps, t;
      bit ok, all_ok;
      for (int i = 0; i < total; i++) lasts.push_back(i == total - 1);
      if (early_last >= 0) lasts[early_last] = 1'b1;
      if (drop_last) lasts[total - 1] = 1'b0;
      // Expected error position from the image rules.
      if (n == 0 || n > 256 || lasts[0]) e = 0;
      else if (m > 32 || lasts[1]) e = 1;
      else
         for (int i = 2; i < total; i++)
            if (e < 0 && lasts[i] != (i == total - 1)) e = i;
      expq.delete();
      last_send = (e >= 0) ? e : total - 1;
      for (int i = 2; i < ((e >= 0) ? e : total); i++)
         if (i < 2 + n) expq.push_back(mk(0, i - 2, img[i], 0));
         else           expq.push_back(mk(1, i - 2 - n, img[i], 0));
      nload = expq.size();
      if (e < 0) begin
         for (int a = n; a < 256; a++) expq.push_back(mk(0, a, 32'd0, 0));
         for (int a = m; a < 32; a++)  expq.push_back(mk(1, a, 32'd0, 0));
         for (int a = 0; a < 32; a++)  expq.push_back(mk(2, a, 32'd0, 0));
      end
      all_ok = 1'b1;
      for (int i = 0; i <= last_send; i++) begin
         if (all_ok) begin
            send(img[i], lasts[i], gap, ok);
            all_ok = all_ok && ok;
         end
      end
      check("xfer_accepted", int'(all_ok), 1);
      if (verify) begin
         t = 0;
         while (!(done_o || err_o) && t < 4000) begin @(negedge clk_i); t++; end
         check("completion_in_budget", int'(done_o || err_o), 1);
         repeat (4) @(negedge clk_i);
         check("xfer_count", xfer_q.size(), last_send + 1);
         check("evt_count", got.size(), expq.size());
         bad = -1;
         for (int i = 0; i < got.size() && i < expq.size(); i++)
            if (bad < 0 && (got[i].kind != expq[i].kind || got[i].addr != expq[i].addr ||
                            got[i].data !== expq[i].data)) bad = i;
         check("evt_first_bad_index", bad, -1);
         check("multi_strobe_cycles", multi, 0);
         tbad = 0;
         for (int i = 0; i < nload; i++)
            if (i >= got.size() || i + 2 >= xfer_q.size() || got[i].cyc != xfer_q[i + 2] + 1)
               tbad++;
         check("load_strobe_timing", tbad, 0);
         check("err", int'(err_o), int'(e >= 0));
         check("start", int'(start_o), int'(e < 0));
         check("done", int'(done_o), int'(e < 0));
         check("cpu_rst", int'(cpu_rst_o), int'(e >= 0));
         check("ready_final", int'(load_ready_o), 0);
         if (e < 0) begin
            gaps = 0;
            for (int i = nload + 1; i < got.size(); i++)
               if (got[i].cyc != got[i - 1].cyc + 1) gaps++;
            check("fill_clear_gaps", gaps, 0);
            check("start_cycle", start_cyc, (got.size() > 0) ? got[got.size() - 1].cyc + 1 : -2);
         end else begin
            check("err_cycle", err_cyc, (xfer_q.size() > e) ? xfer_q[e] + 1 : -2);
         end
      end
   endtask

   initial begin
      int hit;
      rst_i = 1'b0;
      load_valid_i = 1'b0;
      load_data_i = '0;
      load_last_i = 1'b0;
      repeat (2) @(negedge clk_i);
      do_reset();

      tname = "nominal";
      img.delete();
      img.push_back(32'd2); img.push_back(32'd1);
      img.push_back(32'h00A00093); img.push_back(32'h00108113); img.push_back(32'h00000005);
      run_image(-1, 1'b0, 0, 1'b1);

      do_reset(); tname = "max_image";
      build_img(256, 32); run_image(-1, 1'b0, 0, 1'b1);

      do_reset(); tname = "backpressure";
      build_img(5, 3); run_image(-1, 1'b0, 1, 1'b1);

      for (int r = 0; r < 3; r++) begin
         do_reset(); tname = $sformatf("random%0d", r);
         build_img(int'($urandom_range(1, 256)), int'($urandom_range(0, 32)));
         run_image(-1, 1'b0, 2, 1'b1);
      end

      do_reset(); tname = "n_zero";
      build_img(0, 2); run_image(-1, 1'b0, 0, 1'b1);

      do_reset(); tname = "n_257";
      build_img(257, 0); run_image(-1, 1'b0, 0, 1'b1);

      do_reset(); tname = "m_33";
      build_img(4, 33); run_image(-1, 1'b0, 1, 1'b1);

      do_reset(); tname = "early_last_w2";
      build_img(2, 1); run_image(2, 1'b0, 0, 1'b1);

      do_reset(); tname = "missing_last";
      build_img(3, 2); run_image(-1, 1'b1, 1, 1'b1);

      do_reset(); tname = "random_early_last";
      build_img(int'($urandom_range(1, 20)), int'($urandom_range(0, 5)));
      run_image(int'($urandom_range(0, img.size() - 2)), 1'b0, 2, 1'b1);

      do_reset(); tname = "reset_mid_fill";
      build_img(10, 3); run_image(-1, 1'b0, 0, 1'b0);
      hit = 0;
      for (int t = 0; t < 500 && hit == 0; t++) begin
         @(negedge clk_i);
         if (imem_we_o && imem_addr_o == 8'd100) hit = 1;
      end
      check("reached_addr100", hit, 1);
      #2; rst_i = 1'b0;
      @(negedge clk_i);
      check("abort_strobes", int'({imem_we_o, dmem_we_o, rf_we_o}), 0);
      check("last_addr_before_rst", (got.size() > 0) ? got[got.size() - 1].addr : -1, 100);
      @(negedge clk_i); #2;
      clear_mon();
      rst_i = 1'b1;
      @(negedge clk_i);
      check("ready_after_release", int'(load_ready_o), 1);
      repeat (5) @(negedge clk_i);
      check("no_strobes_after_abort", got.size(), 0);
      #2;
      tname = "reload";
      build_img(3, 2); run_image(-1, 1'b0, 0, 1'b1);

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule

// File: doc/cpu_image_loader.md
CPU_IMAGE_LOADER -- requirements
Module: cpu_image_loader

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- IMEM_DEPTH, 256, instruction memory words.
- DMEM_DEPTH, 32, data memory words.
- RF_DEPTH, 32, register file entries.

REQ-002 Ports, one per line (name, direction, width, meaning):
- clk_i, in, 1, single clock; all state updates on its rising edge.
- rst_i, in, 1, reset; synchronous, active-low.
- load_valid_i, in, 1, image word valid.
- load_ready_o, out, 1, loader accepts a word.
- load_data_i, in, 32, image word.
- load_last_i, in, 1, final word of image.
- imem_we_o, out, 1, instruction memory write strobe.
- imem_addr_o, out, 8, instruction word index.
- imem_data_o, out, 32, instruction write data.
- dmem_we_o, out, 1, data memory write strobe.
- dmem_addr_o, out, 5, data word index.
- dmem_data_o, out, 32, data write data.
- rf_we_o, out, 1, register file write strobe.
- rf_addr_o, out, 5, register index.
- rf_data_o, out, 32, register write data; always 0.
- cpu_rst_o, out, 1, CPU reset; active-high; held while loading.
- start_o, out, 1, CPU start.
- done_o, out, 1, image loaded and CPU released.
- err_o, out, 1, malformed image; sticky.

Function
REQ-003 A transfer SHALL occur on a clock edge where load_valid_i and load_ready_o are both 1.
REQ-004 Image format SHALL be: word0 = N (instruction count), word1 = M (data count), then N instruction words, then M data words; load_last_i = 1 on the final word only.
REQ-005 States SHALL be: HDR_I, HDR_D, LOAD_I, LOAD_D, FILL_I, FILL_D, CLR_RF, RUN, ERR.
REQ-006 load_ready_o SHALL be 1 exactly in HDR_I, HDR_D, LOAD_I and LOAD_D, decoded from the state register.
REQ-007 The FSM SHALL move HDR_I -> HDR_D on a transfer; a header with N = 0 or N > IMEM_DEPTH SHALL go to ERR.
REQ-008 From HDR_D, M > DMEM_DEPTH SHALL go to ERR; otherwise the FSM SHALL go to LOAD_I.
REQ-009 The k-th instruction transfer (k from 0) SHALL produce imem_we_o = 1, imem_addr_o = k, imem_data_o = word on the following cycle, one cycle wide.
REQ-010 After the N-th instruction, the FSM SHALL go to LOAD_D if M > 0, else to FILL_I.
REQ-011 The k-th data transfer SHALL produce dmem_we_o = 1, dmem_addr_o = k, dmem_data_o = word on the following cycle.
REQ-012 FILL_I SHALL write 0 to imem addresses N..IMEM_DEPTH-1, one per cycle, ascending; it SHALL be skipped when N = IMEM_DEPTH.
REQ-013 FILL_D SHALL write 0 to dmem addresses M..DMEM_DEPTH-1, one per cycle, ascending; it SHALL be skipped when M = DMEM_DEPTH.
REQ-014 CLR_RF SHALL write 0 to registers 0..31, one per cycle.
REQ-015 There SHALL be no idle cycles between fill and clear phases.
REQ-016 On the cycle after the rf_addr_o = 31 strobe, the FSM SHALL enter RUN: cpu_rst_o = 0, start_o = 1, done_o = 1, held until reset.
REQ-017 Each image word SHALL be checked for the last flag:
- load_last_i = 1 on any word other than word 1+N+M -> ERR.
- load_last_i = 0 on word 1+N+M -> ERR.
REQ-018 In ERR, the block SHALL hold err_o = 1, cpu_rst_o = 1, start_o = 0, load_ready_o = 0 and all write strobes 0 until reset.
REQ-019 When a strobe is 0, its address and data outputs SHALL hold their last value.
REQ-020 At most one write strobe SHALL be 1 in any cycle.

Reset
REQ-021 While rst_i = 0 at a clock edge, the block SHALL enter HDR_I with all counters 0.
REQ-022 Reset values SHALL be:
- load_ready_o, imem_we_o, dmem_we_o, rf_we_o, start_o, done_o, err_o = 0.
- All addresses and data = 0.
- cpu_rst_o = 1.
REQ-023 Reset asserted mid-load, mid-fill, in RUN or in ERR SHALL abort the current operation with no further strobes and restart at HDR_I; load_ready_o = 1 on the first cycle after release.

Verification
REQ-024 Nominal load: words 2, 1, 0x00A00093, 0x00108113, 0x00000005 (last) -> imem[0..1] written, imem 2..255 zero-filled over 254 cycles, dmem[0] = 5, dmem 1..31 zero-filled, 32 rf clears, then start_o = 1 and done_o = 1.
REQ-025 Maximum load: N = 256, M = 32 -> no FILL_I or FILL_D strobes; CLR_RF follows directly; imem_addr_o wraps from 255 without spurious writes.
REQ-026 Backpressure: load_valid_i toggled every other cycle -> strobes occur only after transfers; addresses stay contiguous.
REQ-027 Errors:
- N = 0 -> err_o = 1 one cycle after the header transfer.
- M = 33 -> err_o = 1.
- load_last_i on word 2 of a 5-word image -> err_o = 1, no imem write for that word, start_o stays 0.
REQ-028 Reset mid-FILL_I (at imem_addr_o = 100) -> strobes stop; load_ready_o = 1 after release; a reloaded image completes normally.
